// File: rtl/sh7034_mac_seq_if.sv
// CPU command/register bus and shared 16x16 multiplier port of the MAC sequencer.
// master drives commands and the multiplier product; slave is the sequencer.
interface sh7034_mac_seq_if;
  logic        OP_START;
  logic [3:0]  OP_CODE;
  logic [31:0] OP_RM;
  logic [31:0] OP_RN;
  logic        OP_S;
  logic [1:0]  MAC_SEL;
  logic        MAC_RD;
  logic        MAC_WR;
  logic [31:0] MAC_DI;
  logic [31:0] MAC_DO;
  logic        BUSY;
  logic [15:0] MUL_A;
  logic [15:0] MUL_B;
  logic        MUL_ASGN;
  logic        MUL_BSGN;
  logic [31:0] MUL_P;

  modport master (
    output OP_START, OP_CODE, OP_RM, OP_RN, OP_S,
    output MAC_SEL, MAC_RD, MAC_WR, MAC_DI, MUL_P,
    input  MAC_DO, BUSY, MUL_A, MUL_B, MUL_ASGN, MUL_BSGN
  );

  modport slave (
    input  OP_START, OP_CODE, OP_RM, OP_RN, OP_S,
    input  MAC_SEL, MAC_RD, MAC_WR, MAC_DI, MUL_P,
    output MAC_DO, BUSY, MUL_A, MUL_B, MUL_ASGN, MUL_BSGN
  );
endinterface

// File: rtl/sh7034_mac_seq.sv
// SH-1/SH-2 MACH/MACL owner: sequences 16x16 partial products into a 64-bit acc.
// Define SH7034_MAC_SAT_EN to enable SR.S saturation for MAC.W / MAC.L.
module sh7034_mac_seq #(
  parameter int MACH_W = 10
) (
  input logic CLK,
  input logic RST_N,
  input logic CE_R,
  input logic CE_F,
  input logic RES_N,
  sh7034_mac_seq_if.slave bus
);
  localparam logic [3:0] OP_MULUW = 4'b0110;
  localparam logic [3:0] OP_MULSW = 4'b0111;
  localparam logic [3:0] OP_MULL  = 4'b0001;
  localparam logic [3:0] OP_DMULU = 4'b0010;
  localparam logic [3:0] OP_DMULS = 4'b0011;
  localparam logic [3:0] OP_MACW  = 4'b1011;
  localparam logic [3:0] OP_MACL  = 4'b1001;
  localparam logic [3:0] OP_CLR   = 4'b1111;

  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

  state_t            state;
  logic [1:0]        step;
  logic [63:0]       acc;
  logic [31:0]       ra, rb;
  logic              rs;
  logic [3:0]        rop;
  logic [MACH_W-1:0] mach;
  logic [31:0]       macl;
  logic [15:0]       mul_a, mul_b;
  logic              mul_as, mul_bs;

  function automatic logic is_w(logic [3:0] op);
    return op inside {OP_MULUW, OP_MULSW, OP_MACW};
  endfunction

  function automatic logic is_mul(logic [3:0] op);
    return op inside {OP_MULUW, OP_MULSW, OP_MULL, OP_DMULU,
                      OP_DMULS, OP_MACW, OP_MACL};
  endfunction

  function automatic logic [1:0] last_step(logic [3:0] op);
    if (is_w(op)) return 2'd0;
    if (op == OP_MULL) return 2'd2;
    return 2'd3;
  endfunction

  // step bit0 picks the high half of A, bit1 the high half of B
  function automatic logic [33:0] pp_sel(
    logic [3:0] op, logic [1:0] st,
    logic [31:0] a, logic [31:0] b
  );
    logic w, sw, sl, sa, sb;
    logic [15:0] pa, pb;
    w  = is_w(op);
    sw = (op == OP_MULSW) || (op == OP_MACW);
    sl = (op == OP_DMULS) || (op == OP_MACL);
    pa = st[0] ? a[31:16] : a[15:0];
    pb = st[1] ? b[31:16] : b[15:0];
    sa = w ? sw : (st[0] & sl);
    sb = w ? sw : (st[1] & sl);
    return {sa, sb, pa, pb};
  endfunction

  logic [63:0]        pp_ext, pp_sh;
  logic [33:0]        nxt_sel;
  logic [MACH_W+31:0] sum_mac;
  logic [MACH_W-1:0]  wb_hi;
  logic [31:0]        wb_lo;
  logic               unused_ok;

`ifdef SH7034_MAC_SAT_EN
  logic [63:0] sum64, sum_w, sat_l;
  assign unused_ok = CE_F;
`else
  assign unused_ok = ^{CE_F, rs};
`endif

  always_comb begin
    pp_ext = (mul_as | mul_bs) ? 64'($signed(bus.MUL_P))
                               : {32'b0, bus.MUL_P};
    pp_sh = pp_ext << 16;
    unique case (step)
      2'd0:    pp_sh = pp_ext;
      2'd3:    pp_sh = pp_ext << 32;
      default: pp_sh = pp_ext << 16;
    endcase
    nxt_sel = pp_sel(rop, step + 2'd1, ra, rb);
    sum_mac = {mach, macl} + acc[MACH_W+31:0];
    wb_hi   = sum_mac[MACH_W+31:32];
    wb_lo   = sum_mac[31:0];
`ifdef SH7034_MAC_SAT_EN
    sum64 = 64'($signed({mach, macl})) + acc;
    sum_w = 64'($signed(macl)) + acc;
    sat_l = sum64;
    if ($signed(sum64) > $signed(64'h0000_7FFF_FFFF_FFFF))
      sat_l = 64'h0000_7FFF_FFFF_FFFF;
    else if ($signed(sum64) < $signed(64'hFFFF_8000_0000_0000))
      sat_l = 64'hFFFF_8000_0000_0000;
    if (rs && rop == OP_MACW) begin
      wb_hi = mach;
      if ($signed(sum_w) > $signed(64'h0000_0000_7FFF_FFFF))
        wb_lo = 32'h7FFF_FFFF;
      else if ($signed(sum_w) < $signed(64'hFFFF_FFFF_8000_0000))
        wb_lo = 32'h8000_0000;
      else
        wb_lo = sum_w[31:0];
    end else if (rs && rop == OP_MACL) begin
      wb_hi = sat_l[MACH_W+31:32];
      wb_lo = sat_l[31:0];
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      step   <= 2'd0;
      acc    <= '0;
      ra     <= '0;
      rb     <= '0;
      rs     <= 1'b0;
      rop    <= '0;
      mach   <= '0;
      macl   <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      mul_as <= 1'b0;
      mul_bs <= 1'b0;
    end else if (CE_R) begin
      if (!RES_N) begin
        state  <= IDLE;
        step   <= 2'd0;
        acc    <= '0;
        mul_a  <= '0;
        mul_b  <= '0;
        mul_as <= 1'b0;
        mul_bs <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.MAC_WR) begin
              if (bus.MAC_SEL[0]) macl <= bus.MAC_DI;
              if (bus.MAC_SEL[1]) mach <= bus.MAC_DI[MACH_W-1:0];
            end
            if (bus.OP_START && bus.OP_CODE == OP_CLR) begin
              mach <= '0;
              macl <= '0;
            end else if (bus.OP_START && is_mul(bus.OP_CODE)) begin
              ra    <= bus.OP_RM;
              rb    <= bus.OP_RN;
              rs    <= bus.OP_S;
              rop   <= bus.OP_CODE;
              acc   <= '0;
              step  <= 2'd0;
              state <= MUL;
              {mul_as, mul_bs, mul_a, mul_b} <=
                pp_sel(bus.OP_CODE, 2'd0, bus.OP_RM, bus.OP_RN);
            end
          end
          MUL: begin
            acc <= acc + pp_sh;
            if (step == last_step(rop)) begin
              state  <= WB;
              step   <= 2'd0;
              mul_a  <= '0;
              mul_b  <= '0;
              mul_as <= 1'b0;
              mul_bs <= 1'b0;
            end else begin
              step <= step + 2'd1;
              {mul_as, mul_bs, mul_a, mul_b} <= nxt_sel;
            end
          end
          WB: begin
            state <= IDLE;
            if (rop == OP_MACW || rop == OP_MACL) begin
              mach <= wb_hi;
              macl <= wb_lo;
            end else if (rop == OP_DMULU || rop == OP_DMULS) begin
              mach <= acc[MACH_W+31:32];
              macl <= acc[31:0];
            end else begin
              macl <= acc[31:0];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.BUSY = (state != IDLE) &
                    (bus.OP_START | bus.MAC_RD | bus.MAC_WR);
  assign bus.MAC_DO   = bus.MAC_SEL[1] ? 32'($signed(mach)) : macl;
  assign bus.MUL_A    = mul_a;
  assign bus.MUL_B    = mul_b;
  assign bus.MUL_ASGN = mul_as;
  assign bus.MUL_BSGN = mul_bs;
endmodule

// File: tb/tb_sh7034_mac_seq.sv
// Bench for sh7034_mac_seq: arithmetic reference model plus directed vectors.
// Optional SH7034_MAC_SAT_EN selects saturating expectations.
module tb_sh7034_mac_seq;
  localparam int MW = 10;
  localparam logic [3:0] MULUW = 4'b0110, MULSW = 4'b0111;
  localparam logic [3:0] MULL = 4'b0001, DMULU = 4'b0010;
  localparam logic [3:0] DMULS = 4'b0011, MACW = 4'b1011;
  localparam logic [3:0] MACL = 4'b1001, CLR = 4'b1111;

  logic clk = 0, rst_n = 0, ce_r = 1, ce_f = 0, res_n = 1;
  always #5 clk = ~clk;

  sh7034_mac_seq_if bif();
  sh7034_mac_seq #(.MACH_W(MW)) dut (
    .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .CE_F(ce_f),
    .RES_N(res_n), .bus(bif)
  );

  // external multiplier array
  logic signed [16:0] ma, mb;
  logic signed [33:0] mp;
  always_comb begin
    ma = {bif.MUL_ASGN & bif.MUL_A[15], bif.MUL_A};
    mb = {bif.MUL_BSGN & bif.MUL_B[15], bif.MUL_B};
    mp = ma * mb;
  end
  assign bif.MUL_P = mp[31:0];

  int n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // reference model: MACH kept as its sign-extended 32-bit view
  logic [31:0] m_hi = 0, m_lo = 0, m_a, m_b;
  logic [63:0] m_p;
  logic [3:0]  m_op;
  logic        m_s;
  int          cnt = 0, nst = 0;

  function automatic logic [63:0] fit(logic [63:0] v);
    logic signed [63:0] t;
    t = $signed(v << (32 - MW));
    return t >>> (32 - MW);
  endfunction

  function automatic logic [31:0] hi_of(logic [31:0] d);
    logic signed [31:0] t;
    t = $signed(d << (32 - MW));
    return t >>> (32 - MW);
  endfunction

  function automatic int nsteps(logic [3:0] op);
    if (op inside {MULUW, MULSW, MACW}) return 1;
    if (op == MULL) return 3;
    if (op inside {DMULU, DMULS, MACL}) return 4;
    return 0;
  endfunction

  function automatic logic [63:0] prod(logic [3:0] op,
                                       logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb;
    case (op)
      MULUW: return {48'b0, a[15:0]} * {48'b0, b[15:0]};
      MULSW, MACW: begin
        sa = $signed(a[15:0]);
        sb = $signed(b[15:0]);
        return sa * sb;
      end
      DMULS, MACL: begin
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
      end
      default: return {32'b0, a} * {32'b0, b};
    endcase
  endfunction

  task automatic apply();
    logic [63:0] r, sum;
    logic signed [63:0] sw;
    case (m_op)
      DMULU, DMULS: begin
        r = fit(m_p);
        m_hi = r[63:32];
        m_lo = r[31:0];
      end
      MACW, MACL: begin
        sum = {m_hi, m_lo} + m_p;
`ifdef SH7034_MAC_SAT_EN
        if (m_s && m_op == MACW) begin
          sw = $signed(m_lo);
          sw = sw + $signed(m_p);
          if (sw > 64'sh7FFF_FFFF) m_lo = 32'h7FFF_FFFF;
          else if (sw < -64'sh8000_0000) m_lo = 32'h8000_0000;
          else m_lo = sw[31:0];
          return;
        end
        if (m_s && m_op == MACL) begin
          sw = $signed(sum);
          if (sw > 64'sh7FFF_FFFF_FFFF) sum = 64'h0000_7FFF_FFFF_FFFF;
          else if (sw < -64'sh8000_0000_0000) sum = 64'hFFFF_8000_0000_0000;
        end
`endif
        r = fit(sum);
        m_hi = r[63:32];
        m_lo = r[31:0];
      end
      default: m_lo = m_p[31:0];
    endcase
  endtask

  logic        busy_exp;
  logic [15:0] ea, eb;
  logic        esa, esb, lw, lsw, lsl;
  int          k;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; cnt = 0;
    end else if (ce_r) begin
      if (!res_n) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) apply();
      end else begin
        if (bif.MAC_WR) begin
          if (bif.MAC_SEL[0]) m_lo = bif.MAC_DI;
          if (bif.MAC_SEL[1]) m_hi = hi_of(bif.MAC_DI);
        end
        if (bif.OP_START && bif.OP_CODE == CLR) begin
          m_hi = 0; m_lo = 0;
        end else if (bif.OP_START && nsteps(bif.OP_CODE) > 0) begin
          m_op = bif.OP_CODE; m_a = bif.OP_RM; m_b = bif.OP_RN;
          m_s = bif.OP_S;
          m_p = prod(m_op, m_a, m_b);
          nst = nsteps(m_op);
          cnt = nst + 1;
        end
      end
    end
    #1;
    if (rst_n) begin
      busy_exp = (cnt > 0) && (bif.OP_START || bif.MAC_RD || bif.MAC_WR);
      chk("busy", {31'b0, bif.BUSY}, {31'b0, busy_exp});
      chk("mac_do", bif.MAC_DO, bif.MAC_SEL[1] ? m_hi : m_lo);
      if (cnt == 0) begin
        chk("mul_ab_idle", {bif.MUL_A, bif.MUL_B}, 32'h0);
        chk("mul_sg_idle", {30'b0, bif.MUL_ASGN, bif.MUL_BSGN}, 32'h0);
      end else if (cnt >= 2) begin
        k   = nst + 1 - cnt;
        lw  = m_op inside {MULUW, MULSW, MACW};
        lsw = (m_op == MULSW) || (m_op == MACW);
        lsl = (m_op == DMULS) || (m_op == MACL);
        ea  = (k % 2 == 1) ? m_a[31:16] : m_a[15:0];
        eb  = (k >= 2) ? m_b[31:16] : m_b[15:0];
        esa = lw ? lsw : ((k % 2 == 1) && lsl);
        esb = lw ? lsw : ((k >= 2) && lsl);
        chk("mul_ab", {bif.MUL_A, bif.MUL_B}, {ea, eb});
        chk("mul_sg", {30'b0, bif.MUL_ASGN, bif.MUL_BSGN},
            {30'b0, esa, esb});
      end
    end
  end

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    bif.MAC_WR = 1; bif.MAC_SEL = sel; bif.MAC_DI = d;
    @(posedge clk);
    @(negedge clk);
    bif.MAC_WR = 0;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [31:0] exp,
                    input string nm);
    bif.MAC_SEL = sel; bif.MAC_RD = 1;
    #1 chk(nm, bif.MAC_DO, exp);
  endtask

  task automatic op(input logic [3:0] c, input logic [31:0] a,
                    input logic [31:0] b, input logic s, output int stall);
    bif.OP_START = 1; bif.OP_CODE = c;
    bif.OP_RM = a; bif.OP_RN = b; bif.OP_S = s;
    stall = 0;
    #1;
    while (bif.BUSY && stall < 50) begin
      stall++;
      @(negedge clk);
      #1;
    end
    if (stall >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL op_accept: still busy after %0d cycles", stall);
    end
    @(posedge clk);
    @(negedge clk);
    bif.OP_START = 0;
  endtask

  task automatic wait_idle(output int bc);
    bif.MAC_RD = 1; bif.MAC_SEL = 2'b01;
    bc = 0;
    #1;
    while (bif.BUSY && bc < 50) begin
      bc++;
      @(negedge clk);
      #1;
    end
    bif.MAC_RD = 0;
    if (bc >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: busy after %0d cycles", bc);
    end
  endtask

  int st, bc;

  initial begin
    bif.OP_START = 0; bif.OP_CODE = 0; bif.OP_RM = 0; bif.OP_RN = 0;
    bif.OP_S = 0; bif.MAC_SEL = 0; bif.MAC_RD = 0; bif.MAC_WR = 0;
    bif.MAC_DI = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    rd(2'b01, 32'h0, "rst_macl");
    rd(2'b10, 32'h0, "rst_mach");
    chk("rst_busy", {31'b0, bif.BUSY}, 32'h0);
    chk("rst_mul", {bif.MUL_A, bif.MUL_B}, 32'h0);
    bif.MAC_RD = 0;
    @(negedge clk);

    wr(2'b10, 32'h155);
    op(MULSW, 32'h0000_FFFE, 32'h3, 0, st);
    wait_idle(bc);
    chk("t1_busy_cyc", bc, 2);
    rd(2'b01, 32'hFFFF_FFFA, "t1_macl");
    rd(2'b10, 32'h155, "t1_mach");

    op(DMULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, st);
    wait_idle(bc);
    chk("t2_busy_cyc", bc, 5);
    rd(2'b10, 32'hFFFF_FFFE, "t2u_mach");
    rd(2'b01, 32'h1, "t2u_macl");
    op(DMULS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, st);
    wait_idle(bc);
    rd(2'b10, 32'h0, "t2s_mach");
    rd(2'b01, 32'h1, "t2s_macl");

    wr(2'b01, 32'hFFFF_FFFF);
    wr(2'b10, 32'h0);
    op(MACW, 32'h1, 32'h1, 0, st);
    wait_idle(bc);
    rd(2'b01, 32'h0, "t3a_macl");
    rd(2'b10, 32'h1, "t3a_mach");
    wr(2'b11, 32'hFFFF_FFFF);
    rd(2'b10, 32'hFFFF_FFFF, "t3b_mach_pre");
    op(MACW, 32'h1, 32'h1, 0, st);
    wait_idle(bc);
    rd(2'b10, 32'h0, "t3b_mach");
    rd(2'b01, 32'h0, "t3b_macl");

    wr(2'b01, 32'h7FFF_FFFF);
    wr(2'b10, 32'h0);
    op(MACW, 32'h1, 32'h1, 1, st);
    wait_idle(bc);
`ifdef SH7034_MAC_SAT_EN
    rd(2'b01, 32'h7FFF_FFFF, "t4_macl");
`else
    rd(2'b01, 32'h8000_0000, "t4_macl");
`endif
    rd(2'b10, 32'h0, "t4_mach");

    wr(2'b11, 32'h1234_56AB);
    op(DMULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, st);
    @(negedge clk);
    @(negedge clk);
    res_n = 0;
    @(negedge clk);
    res_n = 1;
    wait_idle(bc);
    chk("t5_busy_cyc", bc, 0);
    rd(2'b10, 32'hFFFF_FEAB, "t5_mach");
    rd(2'b01, 32'h1234_56AB, "t5_macl");
    op(MULUW, 32'hFFFF, 32'hFFFF, 0, st);
    wait_idle(bc);
    rd(2'b01, 32'hFFFE_0001, "t5_mulu");
    rd(2'b10, 32'hFFFF_FEAB, "t5_mach_keep");

    op(MULL, 32'h0001_0002, 32'h0003_0004, 0, st);
    wait_idle(bc);
    chk("t6_busy_cyc", bc, 4);
    rd(2'b01, 32'h000A_0008, "t6_macl");
    wr(2'b01, 32'h0);
    op(MULL, 32'h0001_0002, 32'h0003_0004, 0, st);
    op(MULUW, 32'h3, 32'h5, 0, st);
    chk("t6_stall", st, 4);
    rd(2'b01, 32'h000A_0008, "t6_macl_b");
    wait_idle(bc);
    rd(2'b01, 32'h0000_000F, "t6_second");

    op(DMULS, 32'hFFFF_FFFD, 32'h5, 0, st);
    ce_r = 0;
    repeat (3) @(negedge clk);
    ce_r = 1;
    wait_idle(bc);
    chk("ce_busy_cyc", bc, 5);
    rd(2'b10, 32'hFFFF_FFFF, "ce_mach");
    rd(2'b01, 32'hFFFF_FFF1, "ce_macl");

    wr(2'b11, 32'h0);
    wr(2'b01, 32'h10);
    op(MACL, 32'hFFFF_FFFF, 32'h2, 0, st);
    wait_idle(bc);
    rd(2'b01, 32'hE, "macl_a_lo");
    rd(2'b10, 32'h0, "macl_a_hi");
    op(MACL, 32'hFFFF_FFFD, 32'h5, 0, st);
    wait_idle(bc);
    rd(2'b01, 32'hFFFF_FFFF, "macl_b_lo");
    rd(2'b10, 32'hFFFF_FFFF, "macl_b_hi");

    bif.MAC_WR = 1; bif.MAC_SEL = 2'b01; bif.MAC_DI = 32'hDEAD_BEEF;
    op(MULUW, 32'h2, 32'h3, 0, st);
    bif.MAC_WR = 0;
    rd(2'b01, 32'hDEAD_BEEF, "wrst_wr");
    wait_idle(bc);
    rd(2'b01, 32'h6, "wrst_wb");

    op(CLR, 32'h0, 32'h0, 0, st);
    rd(2'b01, 32'h0, "clr_macl");
    rd(2'b10, 32'h0, "clr_mach");
    bif.MAC_RD = 0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/sh7034_mac_seq.md
Name: sh7034_mac_seq

Overview:
Sequencer and owner of the MACH/MACL multiply-accumulate registers.
- Accepts multiply/MAC commands from the CPU execute stage.
- Splits 32x32 operations into 16x16 partial products, driving one shared external 16x16 multiplier array, and accumulates into a 64-bit working register.
- Writes the results back to MACH/MACL.
- Stalls CPU accesses to MACH/MACL while an operation is in flight.

Parameters:
MACH_W, 10, implemented MACH width (10 = SH-1, 32 = SH-2); 1..32 only.

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
CE_R  in  1  rising-phase clock enable; every state change qualified by it
CE_F  in  1  falling-phase enable; unused, present for uniformity
RES_N  in  1  synchronous soft reset, active low, sampled on CE_R
OP_START  in  1  command valid
OP_CODE  in  4  0110 MULU.W, 0111 MULS.W, 0001 MUL.L, 0010 DMULU.L, 0011 DMULS.L, 1011 MAC.W, 1001 MAC.L, 1111 CLRMAC
OP_RM  in  32  operand A (W ops use [15:0])
OP_RN  in  32  operand B (W ops use [15:0])
OP_S  in  1  SR.S bit for MAC ops
MAC_SEL  in  2  bit0 MACL, bit1 MACH
MAC_RD  in  1  register read (STS)
MAC_WR  in  1  register write (LDS)
MAC_DI  in  32  write data
MAC_DO  out  32  MACH sign-extended from MACH_W if MAC_SEL[1], else MACL
BUSY  out  1  stall request to CPU
MUL_A  out  16  multiplier operand A
MUL_B  out  16  multiplier operand B
MUL_ASGN  out  1  treat MUL_A as signed
MUL_BSGN  out  1  treat MUL_B as signed
MUL_P  in  32  combinational product of MUL_A*MUL_B

Behaviour:
Reset:
- RST_N low: MACH=0, MACL=0, state IDLE, ACC=0, step=0, BUSY=0, MUL_A/MUL_B=0, MUL_ASGN/MUL_BSGN=0.

States and transitions:
- IDLE -> MUL on CE_R with OP_START and OP_CODE a multiply. Latch OP_RM/OP_RN/OP_S/OP_CODE, ACC=0, step=0.
- MUL: one partial product per CE_R: ACC += extended MUL_P << shift.
  - W ops: 1 step, AL*BL, shift 0; signedness per opcode (MAC.W signed).
  - DMULx.L / MAC.L: 4 steps in order AL*BL (0), AH*BL (16), AL*BH (16), AH*BH (32).
  - Low halves always unsigned.
  - High halves signed for DMULS.L / MAC.L, unsigned for DMULU.L.
  - Partial product extended to 64 bits per its operand signs.
  - MUL.L: 3 steps (skips AH*BH); only ACC[31:0] used.
  - After last step -> WB.
- WB (one CE_R), then -> IDLE:
  - MUL*.W, MUL.L: MACL=ACC[31:0]; MACH unchanged.
  - DMULx.L: {MACH,MACL}=ACC truncated to MACH_W+32.
  - MAC.W / MAC.L: {MACH,MACL} = sext({MACH,MACL}) + ACC, truncated to MACH_W+32; saturation only per optional feature.
- CLRMAC in IDLE: MACH=MACL=0 on the same CE_R; no state change.

Latency and stalls:
- Start at CE_R edge n; WB at edge n+steps+1; result readable from edge n+steps+2.
- BUSY = (state!=IDLE) & (OP_START | MAC_RD | MAC_WR). Combinational; the caller holds the request until BUSY=0.
- OP_START while not IDLE is ignored and stalled.

Register access:
- MAC_WR in IDLE on CE_R: write MACL and/or MACH (MACH=MAC_DI[MACH_W-1:0]) per MAC_SEL.
- MAC_WR and OP_START in the same cycle in IDLE: the write takes effect and the op latches operands. The op's WB later overwrites the written value.
- MAC_DO is combinational from the registers at all times.

MUL outputs:
- MUL_A/MUL_B/MUL_ASGN/MUL_BSGN are registered and valid throughout MUL.
- Cleared to 0 in IDLE.

Soft reset:
- RES_N low on CE_R: state IDLE, step=0, ACC=0, in-flight op discarded.
- MACH/MACL unchanged; no WB.

Optional Feature:
Macro SH7034_MAC_SAT_EN.
- Defined: in MAC.W/MAC.L WB with latched OP_S=1, saturate.
  - MAC.W: MACL = sum clamped to signed 32-bit (0x7FFFFFFF / 0x80000000); MACH unchanged.
  - MAC.L: result clamped to signed 48-bit (0x00007FFF_FFFFFFFF / 0xFFFF8000_00000000), truncated to MACH_W+32.
- Undefined: OP_S ignored; wrap-around accumulate always.

Test Plan:
1. MULS.W RM=0xFFFE, RN=0x0003, MACH=0x155 -> after 1 step, MACL=0xFFFFFFFA, MACH=0x155; BUSY on MAC_RD until WB+1.
2. MACH_W=32, DMULU.L 0xFFFFFFFF*0xFFFFFFFF -> MACH=0xFFFFFFFE, MACL=0x00000001 after 4 steps. DMULS.L same operands -> MACH=0, MACL=1.
3. MACH_W=10, MACH=0, MACL=0xFFFFFFFF, MAC.W 1*1, S=0 -> MACL=0, MACH=0x001. MACH=0x3FF, MACL=0xFFFFFFFF, +1 -> MACH=0, MACL=0. MAC_DO for MACH reads 0xFFFFFFFF before the op, 0 after.
4. SAT_EN: MACL=0x7FFFFFFF, MAC.W 1*1, S=1 -> MACL=0x7FFFFFFF. Without the macro -> MACL=0x80000000.
5. DMULU.L started; RES_N low after step 2 -> IDLE, MACH/MACL unchanged. Next MULU.W 0xFFFF*0xFFFF -> MACL=0xFFFE0001.
6. MUL.L 0x00010002*0x00030004 -> exactly 3 MUL steps, MACL=0x000A0008. OP_START during MUL is stalled by BUSY and accepted after return to IDLE.
